spi_burst_memory: RTL and testbench

Parametrised SPI-slave memory, successor to the single-byte SPI memory: mode-0 SPI slave in front of a synchronous RAM with configurable address/data width, optional auto-incrementing burst transfers, and clean abort on chip-select release. Sits between the board SPI pins and on-chip storage. Runs entirely in the FPGA `clk` domain, with SPI pins oversampled.

---
 rtl/spi_mem_pkg.sv | 27 ++
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/spi_burst_memory.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_burst_memory.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared types and constants for the SPI burst memory.
//   spi_mem_state_t : FSM state encoding (3 bits, IDLE = 0)
//   SPI_SYNC_STAGES : synchroniser depth for every SPI pin
//   RW_READ         : value of the header R/W bit that selects a read
//   leds_encode()   : debug LED encoding {1'b0, state[2:0]}
// -----------------------------------------------------------------------------
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        RLOAD  = 3'd2,
        RDATA  = 3'd3,
        WDATA  = 3'd4,
        DONE   = 3'd5
    } spi_mem_state_t;

    localparam int   SPI_SYNC_STAGES = 2;
    localparam logic RW_READ         = 1'b1;

    function automatic logic [3:0] leds_encode(input spi_mem_state_t state);
        return {1'b0, state};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
// Two-flop synchroniser for one SPI pin plus edge detection against a third
// flop. The edge pulses are combinational from flops, so an edge on the pin is
// acted upon by downstream logic on the third clk edge after it appears.
// Ports:
//   i_clk, i_rst_n : FPGA clock, asynchronous active-low reset
//   i_pin          : raw pin
//   o_level        : synchronised level (stage 2)
//   o_rise, o_fall : one-clk pulses on synchronised rising / falling edges
// -----------------------------------------------------------------------------
module spi_pin_sync
    import spi_mem_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SPI_SYNC_STAGES-1:0] r_sync;
    logic                       r_prev;

    // Synchroniser chain plus the history flop used for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SPI_SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SPI_SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SPI_SYNC_STAGES-1];
    assign o_rise  = r_sync[SPI_SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SPI_SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_burst_memory.sv
// -----------------------------------------------------------------------------
// spi_burst_memory
// Mode-0 SPI slave in front of an inferred RAM. A transaction is a header of
// ADDR_W address bits followed by one R/W bit (1 = read), MSB first, then
// DATA_W-bit data words. All logic runs in the clk domain; the SPI pins are
// oversampled through spi_pin_sync.
//
// Build option: define SPI_MEM_BURST_EN for auto-incrementing bursts (address
// wraps modulo 2**ADDR_W). Without it a single word is transferred and the
// FSM parks in DONE until chip select is released.
//
// Parameters: ADDR_W (header/address bits), DATA_W (word width),
//             DEPTH (RAM words, <= 2**ADDR_W)
// Ports:
//   clk, rst_n  : FPGA clock, asynchronous active-low reset
//   sclk_pin    : SPI clock (CPOL=0, CPHA=0)
//   cs_pin      : chip select, active low
//   mosi_pin    : master out / slave in
//   miso_pin    : master in / slave out, high-Z when miso_oe=0
//   miso_oe     : MISO driver enable
//   txn_done    : one-clk pulse per committed word
//   leds        : debug {1'b0, state[2:0]}
// -----------------------------------------------------------------------------
module spi_burst_memory
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic       txn_done,
    output logic [3:0] leds
);

    localparam int MAX_BITS = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

`ifdef SPI_MEM_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    // Synchronised pins
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level,   w_cs_rise,   w_cs_fall;
    logic w_mosi,       w_mosi_rise, w_mosi_fall;
    logic w_unused;

    // FSM and datapath registers
    spi_mem_state_t    r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_shift;
    logic              r_miso;
    logic              r_miso_oe;
    logic              r_txn_done;

    // RAM (contents are deliberately not reset)
    logic [DATA_W-1:0] r_ram [0:DEPTH-1];

    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_wr_word;
    logic              w_we;

    spi_pin_sync u_sync_sclk (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pin   (sclk_pin),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_pin_sync u_sync_cs (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pin   (cs_pin),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_pin_sync u_sync_mosi (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pin   (mosi_pin),
        .o_level (w_mosi),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    // Only the edges actually needed by the FSM are consumed
    assign w_unused = ^{w_sclk_level, w_cs_rise, w_mosi_rise, w_mosi_fall};

    assign w_in_range = ({1'b0, r_addr} < DEPTH_CMP);
    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_rd_data  = w_in_range ? r_ram[w_idx] : '0;
    assign w_wr_word  = {r_shift[DATA_W-2:0], w_mosi};

    // Commit on the last data rise; a simultaneous cs release wins and drops it
    assign w_we = !w_cs_level && (r_state == WDATA) && w_sclk_rise &&
                  (r_bit_cnt == DATA_LAST) && w_in_range;

    // RAM write port
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ram[w_idx] <= w_wr_word;
        end
    end

    // Transaction FSM: header decode, read shift-out, write shift-in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_addr     <= '0;
            r_shift    <= '0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_txn_done <= 1'b0;
        end else begin
            r_txn_done <= 1'b0;
            if (w_cs_level) begin
                // cs high aborts anything in flight; any partial word is lost
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // Start only on a seen cs fall, so a reset taken with
                        // cs already low waits for a fresh high->low select
                        if (w_cs_fall) begin
                            r_state   <= HEADER;
                            r_bit_cnt <= '0;
                        end
                    end
                    HEADER: begin
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == HDR_LAST) begin
                                r_bit_cnt <= '0;
                                if (w_mosi == RW_READ) begin
                                    r_state   <= RLOAD;
                                    r_miso_oe <= 1'b1;
                                end else begin
                                    r_state <= WDATA;
                                end
                            end else begin
                                r_addr    <= {r_addr[ADDR_W-2:0], w_mosi};
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    RLOAD: begin
                        r_shift   <= w_rd_data;
                        r_bit_cnt <= '0;
                        r_state   <= RDATA;
                    end
                    RDATA: begin
                        if (w_sclk_fall) begin
                            r_miso  <= r_shift[DATA_W-1];
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt  <= '0;
                                r_txn_done <= 1'b1;
                                if (BURST_EN) begin
                                    r_addr  <= r_addr + ADDR_ONE;
                                    r_state <= RLOAD;
                                end else begin
                                    r_state <= DONE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_wr_word;
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt  <= '0;
                                r_txn_done <= 1'b1;
                                if (BURST_EN) begin
                                    r_addr <= r_addr + ADDR_ONE;
                                end else begin
                                    r_state <= DONE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        // The last read bit stays valid until the master's
                        // next fall; after that MISO reads as zero
                        if (w_sclk_fall) begin
                            r_miso <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign miso_pin = r_miso_oe ? r_miso : 1'bz;
    assign miso_oe  = r_miso_oe;
    assign txn_done = r_txn_done;
    assign leds     = leds_encode(r_state);

endmodule

// File: tb/tb_spi_burst_memory.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_memory
// Directed bench for spi_burst_memory. Two slaves share sclk/mosi: u_dut8
// (defaults, 8-bit words) on cs0 and u_dut16 (DATA_W=16, DEPTH=100) on cs1.
// Read expectations are queued when a read is issued; monitors assemble the
// words the DUTs shift out on MISO and compare them against the queues.
// -----------------------------------------------------------------------------
module tb_spi_burst_memory;

    localparam int H = 10;   // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs0 = 1'b1;
    logic       cs1 = 1'b1;
    logic       mosi = 1'b0;
    wire        miso0, miso1;
    logic       oe0, oe1, done0, done1;
    logic [3:0] leds0, leds1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt0 = 0, done_cnt1 = 0;
    int exp_done0 = 0, exp_done1 = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] acc0 = '0, acc1 = '0;
    int          nb0 = 0, nb1 = 0;

    always #5 clk = ~clk;

    spi_burst_memory u_dut8 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk), .cs_pin(cs0), .mosi_pin(mosi),
        .miso_pin(miso0), .miso_oe(oe0), .txn_done(done0), .leds(leds0)
    );

    spi_burst_memory #(.ADDR_W(7), .DATA_W(16), .DEPTH(100)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk), .cs_pin(cs1), .mosi_pin(mosi),
        .miso_pin(miso1), .miso_oe(oe1), .txn_done(done1), .leds(leds1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // txn_done pulse counters
    always @(negedge clk) begin
        if (done0 === 1'b1) done_cnt0++;
        if (done1 === 1'b1) done_cnt1++;
    end

    // MISO monitor, 8-bit slave: sample on master's rising sclk
    always @(posedge sclk or posedge cs0) begin
        if (cs0) begin
            nb0 = 0;
        end else if (oe0) begin
            acc0 = {acc0[14:0], miso0};
            nb0++;
            if (nb0 == 8) begin
                nb0 = 0;
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd8_unexpected: got 0x%0h expected no read", acc0[7:0]);
                end else begin
                    check("rd8_data", {24'b0, acc0[7:0]}, {16'b0, q0.pop_front()});
                end
            end
        end
    end

    // MISO monitor, 16-bit slave
    always @(posedge sclk or posedge cs1) begin
        if (cs1) begin
            nb1 = 0;
        end else if (oe1) begin
            acc1 = {acc1[14:0], miso1};
            nb1++;
            if (nb1 == 16) begin
                nb1 = 0;
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd16_unexpected: got 0x%0h expected no read", acc1);
                end else begin
                    check("rd16_data", {16'b0, acc1}, {16'b0, q1.pop_front()});
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cs(input int which, input logic v);
        if (which == 0) cs0 = v; else cs1 = v;
    endtask

    task automatic cs_drop(input int which);
        wait_clk(1);
        set_cs(which, 1'b0);
        wait_clk(6);
    endtask

    task automatic cs_raise(input int which);
        wait_clk(H);
        set_cs(which, 1'b1);
        wait_clk(8);
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_write(input int which, input logic [6:0] addr,
                             input logic [15:0] data, input int dw);
        cs_drop(which);
        shift_bits({24'b0, addr, 1'b0}, 8);
        shift_bits({16'b0, data}, dw);
        cs_raise(which);
        if (which == 0) exp_done0++; else exp_done1++;
    endtask

    task automatic spi_read(input int which, input logic [6:0] addr,
                            input logic [15:0] exp, input int dw);
        if (which == 0) q0.push_back(exp); else q1.push_back(exp);
        cs_drop(which);
        shift_bits({24'b0, addr, 1'b1}, 8);
        shift_bits(32'b0, dw);
        cs_raise(which);
        if (which == 0) exp_done0++; else exp_done1++;
    endtask

    initial begin
        // Power-on reset
        wait_clk(5);
        check("rst_oe", {31'b0, oe0}, 32'd0);
        check("rst_done", {31'b0, done0}, 32'd0);
        check("rst_leds", {28'b0, leds0}, 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        // Single write then read-back at 0x12
        spi_write(0, 7'h12, 16'h00A5, 8);
        check("done_wr_a5", done_cnt0, exp_done0);
        spi_read(0, 7'h12, 16'h00A5, 8);
        check("done_rd_a5", done_cnt0, exp_done0);

        // Reset in the middle of a header with sclk still toggling
        cs_drop(0);
        shift_bits(32'h12, 5);
        check("hdr_leds", {28'b0, leds0}, 32'd1);
        rst_n = 1'b0;
        shift_bits(32'h0, 3);
        check("midrst_oe", {31'b0, oe0}, 32'd0);
        check("midrst_done", {31'b0, done0}, 32'd0);
        check("midrst_leds", {28'b0, leds0}, 32'd0);
        rst_n = 1'b1;
        // cs still low: this write must not be seen
        shift_bits({24'b0, 7'h12, 1'b0}, 8);
        shift_bits(32'hFF, 8);
        check("ghost_leds", {28'b0, leds0}, 32'd0);
        check("ghost_oe", {31'b0, oe0}, 32'd0);
        cs_raise(0);
        check("ghost_done", done_cnt0, exp_done0);
        spi_read(0, 7'h12, 16'h00A5, 8);

`ifdef SPI_MEM_BURST_EN
        // Burst write 3 words from 0x7F, wrapping to 0x00, 0x01
        cs_drop(0);
        shift_bits({24'b0, 7'h7F, 1'b0}, 8);
        shift_bits(32'h11, 8);
        shift_bits(32'h22, 8);
        shift_bits(32'h33, 8);
        cs_raise(0);
        exp_done0 += 3;
        check("done_bwr", done_cnt0, exp_done0);
        q0.push_back(16'h11); q0.push_back(16'h22); q0.push_back(16'h33);
        cs_drop(0);
        shift_bits({24'b0, 7'h7F, 1'b1}, 8);
        shift_bits(32'h0, 24);
        cs_raise(0);
        exp_done0 += 3;
        check("done_brd", done_cnt0, exp_done0);
        spi_read(0, 7'h01, 16'h0033, 8);
`else
        // Two words in one window: only the first is stored
        spi_write(0, 7'h04, 16'h003C, 8);
        cs_drop(0);
        shift_bits({24'b0, 7'h03, 1'b0}, 8);
        shift_bits(32'h5A, 8);
        shift_bits(32'hFF, 8);
        check("done_leds", {28'b0, leds0}, 32'd5);
        cs_raise(0);
        exp_done0++;
        check("done_nb", done_cnt0, exp_done0);
        spi_read(0, 7'h03, 16'h005A, 8);
        spi_read(0, 7'h04, 16'h003C, 8);
`endif

        // Write abort after 5 data bits
        spi_write(0, 7'h20, 16'h0077, 8);
        cs_drop(0);
        shift_bits({24'b0, 7'h20, 1'b0}, 8);
        shift_bits(32'h15, 5);
        wait_clk(H);
        cs0 = 1'b1;
        wait_clk(3);
        check("abort_leds", {28'b0, leds0}, 32'd0);
        check("abort_oe", {31'b0, oe0}, 32'd0);
        wait_clk(8);
        check("abort_done", done_cnt0, exp_done0);
        spi_read(0, 7'h20, 16'h0077, 8);

        // Read abort: MISO driver must drop within 3 clk of cs
        cs_drop(0);
        shift_bits({24'b0, 7'h12, 1'b1}, 8);
        shift_bits(32'h0, 2);
        wait_clk(4);
        check("rabort_oe_on", {31'b0, oe0}, 32'd1);
        cs0 = 1'b1;
        wait_clk(3);
        check("rabort_oe_off", {31'b0, oe0}, 32'd0);
        wait_clk(8);
        check("rabort_done", done_cnt0, exp_done0);

        // 16-bit slave with DEPTH=100
        spi_write(1, 7'h10, 16'hBEEF, 16);
        spi_read(1, 7'h10, 16'hBEEF, 16);
        spi_write(1, 7'h70, 16'h1234, 16);
        check("done16_oor_wr", done_cnt1, exp_done1);
        spi_read(1, 7'h70, 16'h0000, 16);
        check("done16", done_cnt1, exp_done1);
        check("leds16_idle", {28'b0, leds1}, 32'd0);

        // Every queued read must have been delivered
        wait_clk(20);
        check("q8_drained", q0.size(), 32'd0);
        check("q16_drained", q1.size(), 32'd0);
        check("done8_total", done_cnt0, exp_done0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
